// File: rtl/reg_shift_sipo_rx.sv
// Serial-in/parallel-out receive register: assembles WIDTH-bit words sampled on
// bit_en while din_valid frames the word, with a valid/ack output and sticky error flags.
module reg_shift_sipo_rx #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             din,
  input  logic             din_valid,
  input  logic             rd_ack,
  input  logic             err_clr,
  output logic [WIDTH-1:0] Dout,
  output logic             dout_valid,
  output logic             rx_done,
  output logic             rx_busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  logic [0:0]       state_q,      state_d;
  logic [WIDTH-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] dout_q,       dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             rx_done_q,    rx_done_d;
  logic             overrun_q,    overrun_d;
  logic             frame_err_q,  frame_err_d;
  logic [WIDTH-1:0] shifted;

  // MSB-first shifts left (new bit at LSB); LSB-first shifts right (new bit at MSB).
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
    if (MSB_FIRST) return {cur[WIDTH-2:0], b};
    else           return {b, cur[WIDTH-1:1]};
  endfunction

  assign shifted = shift_in(shift_q, din);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    rx_done_d    = 1'b0;
    overrun_d    = overrun_q;
    frame_err_d  = frame_err_q;

    if (rd_ack) dout_valid_d = 1'b0;
    // Clears come first so an error event later in this block overrides them.
    if (err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (din_valid && bit_en) begin
          shift_d = shift_in('0, din);
          cnt_d   = CNT_W'(1);
          state_d = ST_RECV;
        end
      end
      ST_RECV: begin
        if (!din_valid) begin
          frame_err_d = 1'b1;
          shift_d     = '0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else if (bit_en) begin
          if (cnt_q == LAST_IDX) begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
            // An ack in the completion cycle frees the holding register for this word.
            if (!dout_valid_q || rd_ack) begin
              dout_d       = shifted;
              dout_valid_d = 1'b1;
              rx_done_d    = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      rx_done_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      rx_done_q    <= rx_done_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign Dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign rx_done    = rx_done_q;
  assign rx_busy    = (state_q == ST_RECV);
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_reg_shift_sipo_rx.sv
// Directed bench for reg_shift_sipo_rx: one MSB-first and one LSB-first instance
// share the stimulus; expected values are hand-computed constants.
module tb_reg_shift_sipo_rx;

  logic        clk = 1'b0;
  logic        reset, bit_en, din, din_valid, rd_ack, err_clr;
  logic [31:0] m_dout, l_dout;
  logic        m_valid, m_done, m_busy, m_ovr, m_ferr;
  logic        l_valid, l_done, l_busy, l_ovr, l_ferr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_shift_sipo_rx #(.WIDTH(32), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .din(din), .din_valid(din_valid),
    .rd_ack(rd_ack), .err_clr(err_clr), .Dout(m_dout), .dout_valid(m_valid),
    .rx_done(m_done), .rx_busy(m_busy), .overrun(m_ovr), .frame_err(m_ferr)
  );

  reg_shift_sipo_rx #(.WIDTH(32), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .reset(reset), .bit_en(bit_en), .din(din), .din_valid(din_valid),
    .rd_ack(rd_ack), .err_clr(err_clr), .Dout(l_dout), .dout_valid(l_valid),
    .rx_done(l_done), .rx_busy(l_busy), .overrun(l_ovr), .frame_err(l_ferr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends nbits of word, one bit_en strobe every 2 clk; returns #1 after the edge
  // that consumed the last strobe, with din_valid still high.
  task automatic send_word(input logic [31:0] word, input int nbits, input bit lsb_first,
                           input bit chk_busy, input bit ack_last);
    for (int i = 0; i < nbits; i++) begin
      din_valid = 1'b1;
      bit_en    = 1'b1;
      din       = word[lsb_first ? i : 31 - i];
      rd_ack    = ack_last && (i == nbits - 1);
      tick();
      bit_en = 1'b0;
      rd_ack = 1'b0;
      if (chk_busy && i == 0) check("busy_mid_frame", 32'(m_busy), 32'd1);
      if (i != nbits - 1) tick();
    end
  endtask

  task automatic idle_ack();
    din_valid = 1'b0;
    rd_ack    = 1'b1;
    tick();
    rd_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; bit_en = 1'b0; din = 1'b0; din_valid = 1'b0; rd_ack = 1'b0; err_clr = 1'b0;

    // 1. reset
    tick(); tick();
    reset = 1'b1;
    tick();
    check("rst_dout",   m_dout,          32'h0);
    check("rst_valid",  32'(m_valid),    32'd0);
    check("rst_done",   32'(m_done),     32'd0);
    check("rst_busy",   32'(m_busy),     32'd0);
    check("rst_ovr",    32'(m_ovr),      32'd0);
    check("rst_ferr",   32'(m_ferr),     32'd0);
    check("rst_l_dout", l_dout,          32'h0);

    // 2. MSB-first word
    send_word(32'hF0F0FF0F, 32, 1'b0, 1'b1, 1'b0);
    check("t2_dout",  m_dout,       32'hF0F0FF0F);
    check("t2_done",  32'(m_done),  32'd1);
    check("t2_valid", 32'(m_valid), 32'd1);
    check("t2_busy",  32'(m_busy),  32'd0);
    din_valid = 1'b0;
    tick();
    check("t2_done_pulse", 32'(m_done),  32'd0);
    check("t2_valid_hold", 32'(m_valid), 32'd1);
    check("t2_no_ferr",    32'(m_ferr),  32'd0);
    idle_ack();
    check("t2_ack_valid", 32'(m_valid), 32'd0);
    check("t2_ack_dout",  m_dout,       32'hF0F0FF0F);

    // 3. overrun
    send_word(32'h12345678, 32, 1'b0, 1'b0, 1'b0);
    check("t3_first_dout", m_dout,      32'h12345678);
    check("t3_first_done", 32'(m_done), 32'd1);
    din_valid = 1'b0;
    tick();
    send_word(32'hDEADBEEF, 32, 1'b0, 1'b0, 1'b0);
    check("t3_ovr_dout",  m_dout,       32'h12345678);
    check("t3_ovr_done",  32'(m_done),  32'd0);
    check("t3_ovr_flag",  32'(m_ovr),   32'd1);
    check("t3_ovr_valid", 32'(m_valid), 32'd1);
    din_valid = 1'b0;
    err_clr   = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t3_ovr_clr", 32'(m_ovr), 32'd0);
    idle_ack();

    // 4. framing error after 10 bits
    send_word(32'hAAAAAAAA, 10, 1'b0, 1'b0, 1'b0);
    check("t4_busy_pre", 32'(m_busy), 32'd1);
    din_valid = 1'b0;
    tick();
    check("t4_ferr",  32'(m_ferr),  32'd1);
    check("t4_busy",  32'(m_busy),  32'd0);
    check("t4_dout",  m_dout,       32'h12345678);
    check("t4_valid", 32'(m_valid), 32'd0);
    send_word(32'h0000FFFF, 32, 1'b0, 1'b0, 1'b0);
    check("t4_next_dout", m_dout,       32'h0000FFFF);
    check("t4_next_done", 32'(m_done),  32'd1);
    check("t4_ferr_sticky", 32'(m_ferr), 32'd1);
    din_valid = 1'b0;
    err_clr   = 1'b1;
    rd_ack    = 1'b1;
    tick();
    err_clr = 1'b0;
    rd_ack  = 1'b0;
    check("t4_ferr_clr", 32'(m_ferr), 32'd0);

    // 5. completion coinciding with rd_ack
    send_word(32'h11111111, 32, 1'b0, 1'b0, 1'b0);
    din_valid = 1'b0;
    tick();
    send_word(32'h22222222, 32, 1'b0, 1'b0, 1'b1);
    check("t5_dout",  m_dout,       32'h22222222);
    check("t5_valid", 32'(m_valid), 32'd1);
    check("t5_ovr",   32'(m_ovr),   32'd0);
    check("t5_done",  32'(m_done),  32'd1);

    // 6. reset mid-frame, then recovery
    din_valid = 1'b0;
    tick();
    send_word(32'h5555AAAA, 16, 1'b0, 1'b0, 1'b0);
    reset     = 1'b0;
    bit_en    = 1'b1;
    din       = 1'b1;
    din_valid = 1'b1;
    tick();
    reset     = 1'b1;
    bit_en    = 1'b0;
    din_valid = 1'b0;
    check("t6_rst_dout",  m_dout,       32'h0);
    check("t6_rst_valid", 32'(m_valid), 32'd0);
    check("t6_rst_busy",  32'(m_busy),  32'd0);
    check("t6_rst_done",  32'(m_done),  32'd0);
    check("t6_rst_ovr",   32'(m_ovr),   32'd0);
    check("t6_rst_ferr",  32'(m_ferr),  32'd0);
    tick();
    send_word(32'hCAFEF00D, 32, 1'b0, 1'b0, 1'b0);
    check("t6_cafe_dout", m_dout,      32'hCAFEF00D);
    check("t6_cafe_done", 32'(m_done), 32'd1);
    idle_ack();

    // LSB-first stimulus: the LSB-first instance rebuilds the word, the MSB-first
    // instance sees it bit-reversed.
    send_word(32'hF0F0FF0F, 32, 1'b1, 1'b0, 1'b0);
    check("t6_lsb_dout", l_dout,      32'hF0F0FF0F);
    check("t6_lsb_done", 32'(l_done), 32'd1);
    check("t6_lsb_busy", 32'(l_busy), 32'd0);
    check("t6_msb_rev",  m_dout,      32'hF0FF0F0F);
    din_valid = 1'b0;
    tick();
    check("t6_lsb_ferr", 32'(l_ferr), 32'd0);
    check("t6_lsb_ovr",  32'(l_ovr),  32'd0);
    check("t6_lsb_valid", 32'(l_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
